// File: rtl/test_harness.sv
// Test harness: a small command engine fetching 64-bit words from a backdoor-loaded RAM,
// driving a host mailbox, a retired-command counter and an 8N1 UART transmitter/receiver.
module test_harness #(
  parameter int MEM_WORDS = 4096,
  parameter int CLK_DIV   = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_uart_tx,
  input  logic        io_uart_rx,
  output logic [63:0] tohost,
  output logic [31:0] taint_sum
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(CLK_DIV);

  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  localparam logic [7:0] OP_HALT   = 8'h00;
  localparam logic [7:0] OP_SEND   = 8'h01;
  localparam logic [7:0] OP_TOHOST = 8'h02;
  localparam logic [7:0] OP_JUMP   = 8'h03;

  typedef enum logic [1:0] {FETCH, EXEC, WAIT_TX, HALT} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  logic [63:0]   ram [MEM_WORDS];
  logic [63:0]   cmd_p1;
  logic [7:0]    op;
  logic [55:0]   payload;
  state_t        state;
  logic [AW-1:0] pc;
  logic          fetch_en;

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_tick;
  logic          tx_last;
  logic          tx_ready;
  logic          tx_launch;

  rx_state_t     rx_state;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick;
  logic          rx_vld_p1;
  logic [7:0]    rx_byte_p1;

  assign op       = cmd_p1[63:56];
  assign payload  = cmd_p1[55:0];
  assign fetch_en = (state == FETCH);

  // ---- stage p0 -> p1: RAM read into command register; RX write-back (read sees old data)
  always_ff @(posedge clock) begin
    if (rx_vld_p1)
      ram[LAST_WORD] <= {ram[LAST_WORD][63:8] + 56'd1, rx_byte_p1};
    if (fetch_en)
      cmd_p1 <= ram[pc];
  end

  // ---- stage p1: decode and retire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      tohost    <= '0;
      taint_sum <= '0;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          case (op)
            OP_HALT: state <= HALT;
            OP_SEND: begin
              if (tx_ready) begin
                pc        <= pc_inc(pc);
                taint_sum <= cnt_inc(taint_sum);
                state     <= FETCH;
              end else begin
                state <= WAIT_TX;
              end
            end
            OP_TOHOST: begin
              tohost    <= {8'h00, payload};
              pc        <= pc_inc(pc);
              taint_sum <= cnt_inc(taint_sum);
              state     <= FETCH;
            end
            OP_JUMP: begin
              pc        <= cmd_p1[AW-1:0];
              taint_sum <= cnt_inc(taint_sum);
              state     <= FETCH;
            end
            default: begin
              pc        <= pc_inc(pc);
              taint_sum <= cnt_inc(taint_sum);
              state     <= FETCH;
            end
          endcase
        end
        WAIT_TX: begin
          if (tx_ready) begin
            pc        <= pc_inc(pc);
            taint_sum <= cnt_inc(taint_sum);
            state     <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  // Accepting a launch in the final stop-bit cycle lets back-to-back frames abut exactly.
  assign tx_tick   = tx_busy && (tx_cnt == TICK_LAST);
  assign tx_last   = tx_tick && (tx_bit == 4'd9);
  assign tx_ready  = !tx_busy || tx_last;
  assign tx_launch = tx_ready && (((state == EXEC) && (op == OP_SEND)) || (state == WAIT_TX));

  // ---- TX serializer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_busy    <= 1'b0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      io_uart_tx <= 1'b1;
    end else if (tx_launch) begin
      tx_busy    <= 1'b1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      io_uart_tx <= 1'b0;
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          io_uart_tx <= tx_shift[0];
          tx_bit     <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tx_launch)
      tx_shift <= {1'b1, cmd_p1[7:0]};
    else if (tx_tick)
      tx_shift <= {1'b1, tx_shift[8:1]};
  end

  // ---- RX deserializer
  assign rx_tick = (rx_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_vld_p1 <= 1'b0;
    end else begin
      rx_s1     <= io_uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_vld_p1 <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7)
              rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: begin
          if (rx_tick) begin
            rx_cnt    <= '0;
            rx_vld_p1 <= rx_s2;
            rx_state  <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((rx_state == RX_DATA) && rx_tick)
      rx_shift <= {rx_s2, rx_shift[7:1]};
    if ((rx_state == RX_STOP) && rx_tick)
      rx_byte_p1 <= rx_shift;
  end

endmodule

// File: tb/tb_test_harness.sv
// Self-checking bench for test_harness: scoreboarded UART traffic, mailbox, counter and reset behaviour.
module tb_test_harness;

  localparam int MW   = 64;
  localparam int CD   = 16;
  localparam int LAST = MW - 1;

  logic        clock;
  logic        reset;
  logic        io_uart_tx;
  logic        io_uart_rx;
  logic [63:0] tohost;
  logic [31:0] taint_sum;

  int n_cmp;
  int n_bad;
  int cyc;
  logic mon_en;

  logic [63:0] tx_exp_q[$];
  logic [63:0] rx_exp_q[$];
  int          start_cyc_q[$];

  test_harness #(.MEM_WORDS(MW), .CLK_DIV(CD)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_uart_tx (io_uart_tx),
    .io_uart_rx (io_uart_rx),
    .tohost     (tohost),
    .taint_sum  (taint_sum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < MW; i++) dut.ram[i] = 64'h0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int k;
    k = 0;
    while (tx_exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_val("tx_drain", 64'(tx_exp_q.size()), 64'd0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    io_uart_rx = 1'b0;
    repeat (CD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      io_uart_rx = b[i];
      repeat (CD) @(negedge clock);
    end
    io_uart_rx = stop_bit;
    repeat (CD) @(negedge clock);
    io_uart_rx = 1'b1;
    repeat (2 * CD) @(negedge clock);
  endtask

  // UART line monitor: decodes each frame at bit centres and scores it against the queue
  initial begin : tx_monitor
    logic [7:0]  b;
    logic        stp;
    logic [63:0] want;
    forever begin
      @(negedge clock);
      if (mon_en && io_uart_tx === 1'b0) begin
        start_cyc_q.push_back(cyc);
        repeat (CD / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CD) @(negedge clock);
          b[i] = io_uart_tx;
        end
        repeat (CD) @(negedge clock);
        stp = io_uart_tx;
        want = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 64'h1FF;
        check_val("tx_byte", {56'h0, b}, want);
        check_val("tx_stop", {63'h0, stp}, 64'd1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int lowcnt;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    mon_en = 1'b1;
    reset = 1'b0;
    io_uart_rx = 1'b1;
    for (int i = 0; i < MW; i++) dut.ram[i] = 64'h0;

    // reset state
    repeat (3) @(negedge clock);
    check_val("rst_tx", {63'h0, io_uart_tx}, 64'd1);
    check_val("rst_tohost", tohost, 64'd0);
    check_val("rst_taint", {32'h0, taint_sum}, 64'd0);
    check_val("rst_pc", 64'(dut.pc), 64'd0);
    check_val("rst_state", 64'(dut.state), 64'd0);
    check_val("rst_sync", {62'h0, dut.rx_s1, dut.rx_s2}, 64'd3);

    // TOHOST then HALT
    hold_reset();
    dut.ram[0] = {8'h02, 56'h1};
    dut.ram[1] = 64'h0;
    release_reset();
    @(posedge clock); #1;
    check_val("tohost_after_fetch", tohost, 64'd0);
    @(posedge clock); #1;
    check_val("tohost_after_exec", tohost, 64'd1);
    check_val("taint_tohost", {32'h0, taint_sum}, 64'd1);
    repeat (4) @(posedge clock); #1;
    check_val("halt_state", 64'(dut.state), 64'd3);
    check_val("halt_taint", {32'h0, taint_sum}, 64'd1);

    // single SEND 0xA5
    hold_reset();
    dut.ram[0] = {8'h01, 56'hA5};
    tx_exp_q.push_back(64'hA5);
    release_reset();
    @(posedge clock); #1;
    check_val("tx_idle_at_fetch", {63'h0, io_uart_tx}, 64'd1);
    @(posedge clock); #1;
    check_val("tx_start_after_launch", {63'h0, io_uart_tx}, 64'd0);
    lowcnt = 0;
    @(negedge clock);
    while (io_uart_tx == 1'b0 && lowcnt < 100) begin
      lowcnt++;
      @(negedge clock);
    end
    check_val("tx_start_len", 64'(lowcnt), 64'(CD));
    wait_tx_drain(12 * CD);
    check_val("taint_send", {32'h0, taint_sum}, 64'd1);

    // back-to-back SENDs
    hold_reset();
    dut.ram[0] = {8'h01, 56'h55};
    dut.ram[1] = {8'h01, 56'h0F};
    start_cyc_q.delete();
    tx_exp_q.push_back(64'h55);
    tx_exp_q.push_back(64'h0F);
    release_reset();
    wait_tx_drain(24 * CD);
    if (start_cyc_q.size() >= 2)
      check_val("b2b_gap", 64'(start_cyc_q[1] - start_cyc_q[0]), 64'(10 * CD));
    else
      check_val("b2b_starts", 64'(start_cyc_q.size()), 64'd2);
    check_val("taint_b2b", {32'h0, taint_sum}, 64'd2);

    // RX: good frame, bad stop, glitch, second good frame
    hold_reset();
    release_reset();
    rx_exp_q.push_back({56'h1, 8'h3C});
    rx_frame(8'h3C, 1'b1);
    check_val("rx_good", dut.ram[LAST], rx_exp_q.pop_front());
    rx_exp_q.push_back({56'h1, 8'h3C});
    rx_frame(8'h99, 1'b0);
    check_val("rx_bad_stop", dut.ram[LAST], rx_exp_q.pop_front());
    rx_exp_q.push_back({56'h1, 8'h3C});
    @(negedge clock);
    io_uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    io_uart_rx = 1'b1;
    repeat (3 * CD) @(negedge clock);
    check_val("rx_glitch", dut.ram[LAST], rx_exp_q.pop_front());
    rx_exp_q.push_back({56'h2, 8'hA5});
    rx_frame(8'hA5, 1'b1);
    check_val("rx_second", dut.ram[LAST], rx_exp_q.pop_front());

    // TOHOST/JUMP loop for 100 cycles, then reset mid-run
    hold_reset();
    dut.ram[0] = {8'h02, 56'hABC};
    dut.ram[1] = {8'h03, 56'h0};
    release_reset();
    repeat (100) @(posedge clock); #1;
    check_val("loop_taint", {32'h0, taint_sum}, 64'd50);
    check_val("loop_tohost", tohost, 64'hABC);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst_taint", {32'h0, taint_sum}, 64'd0);
    check_val("async_rst_tohost", tohost, 64'd0);

    // reset mid-frame: line returns high and no frame resumes
    mon_en = 1'b0;
    hold_reset();
    dut.ram[0] = {8'h01, 56'h00};
    release_reset();
    repeat (40) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_val("abort_tx_high", {63'h0, io_uart_tx}, 64'd1);
    dut.ram[0] = 64'h0;
    release_reset();
    lowcnt = 0;
    repeat (200) begin
      @(negedge clock);
      if (io_uart_tx == 1'b0) lowcnt++;
    end
    check_val("abort_no_resume", 64'(lowcnt), 64'd0);
    mon_en = 1'b1;

    // JUMP modulo MEM_WORDS and pc wrap from the last word
    hold_reset();
    dut.ram[0]    = {8'h03, 24'h0, 32'h0001_003F};
    dut.ram[LAST] = {8'h7F, 56'h0};
    release_reset();
    repeat (2) @(posedge clock); #1;
    check_val("jump_mod_pc", 64'(dut.pc), 64'(LAST));
    repeat (2) @(posedge clock); #1;
    check_val("wrap_pc", 64'(dut.pc), 64'd0);
    check_val("wrap_taint", {32'h0, taint_sum}, 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
